// File: rtl/ng_sched_pkg.sv
// ng_sched_pkg
//   Shared definitions for the subsequence scheduler.
//   Contents: SUBSEQ encoding, scheduler FSM state type, and the time pulse
//   count (TPG) constants used by the scheduler and its bench.
package ng_sched_pkg;

  localparam int TPG_W = 4;

  localparam logic [TPG_W-1:0] TPG_STBY  = 4'd0;
  localparam logic [TPG_W-1:0] TPG_PWRON = 4'd1;
  localparam logic [TPG_W-1:0] TPG_TP1   = 4'd2;
  localparam logic [TPG_W-1:0] TPG_TP12  = 4'd13;
  localparam logic [TPG_W-1:0] TPG_SRLSE = 4'd14;
  localparam logic [TPG_W-1:0] TPG_WAIT  = 4'd15;

  typedef enum logic [1:0] {
    SS_STD  = 2'd0,
    SS_CINC = 2'd1,
    SS_RUPT = 2'd2,
    SS_IDLE = 2'd3
  } subseq_e;

  typedef enum logic [1:0] {
    STBY   = 2'd0,
    RUN    = 2'd1,
    DECIDE = 2'd2
  } state_e;

endpackage

// File: rtl/ng_subseq_sched_if.sv
// ng_subseq_sched_if
//   Bundles the scheduler's timing, request and dispatch signals.
//   master: drives TPG, LAST, CNT_REQ, RUPT_REQ, INHINT, RESUME;
//           observes SNI, INST, SUBSEQ, CNT_ADDR, RUPT_VEC, CNT_PEND,
//           RUPT_PEND, IIP.
//   slave : the scheduler side (directions reversed).
interface ng_subseq_sched_if
  import ng_sched_pkg::*;
#(
  parameter int NCNT  = 8,
  parameter int NRUPT = 5
);
  logic [TPG_W-1:0]         TPG;
  logic                     LAST;
  logic [NCNT-1:0]          CNT_REQ;
  logic [NRUPT-1:0]         RUPT_REQ;
  logic                     INHINT;
  logic                     RESUME;
  logic                     SNI;
  logic                     INST;
  logic [1:0]               SUBSEQ;
  logic [$clog2(NCNT)-1:0]  CNT_ADDR;
  logic [$clog2(NRUPT)-1:0] RUPT_VEC;
  logic [NCNT-1:0]          CNT_PEND;
  logic [NRUPT-1:0]         RUPT_PEND;
  logic                     IIP;

  modport master (
    output TPG, LAST, CNT_REQ, RUPT_REQ, INHINT, RESUME,
    input  SNI, INST, SUBSEQ, CNT_ADDR, RUPT_VEC, CNT_PEND, RUPT_PEND, IIP
  );

  modport slave (
    input  TPG, LAST, CNT_REQ, RUPT_REQ, INHINT, RESUME,
    output SNI, INST, SUBSEQ, CNT_ADDR, RUPT_VEC, CNT_PEND, RUPT_PEND, IIP
  );
endinterface

// File: rtl/ng_prio_enc.sv
// ng_prio_enc
//   Lowest-index-first priority encoder.
//   req   : request vector, N bits
//   idx   : index of the lowest set bit (0 when none set)
//   valid : at least one bit of req is set
module ng_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ng_subseq_sched.sv
// ng_subseq_sched
//   Chooses the subsequence run after each instruction step: counter
//   increment (CINC), interrupt entry (RUPT) or the standard next-instruction
//   fetch (STD). The choice is made once per TP12 and held until the next.
//   CLK1  : sole clock, rising edge
//   PURST : synchronous active-high reset
//   bus   : slave side of ng_subseq_sched_if (TPG/LAST/requests in,
//           dispatch results and pending state out)
//
//   state  | meaning
//   STBY   | TPG at 0/1, nothing dispatched, SUBSEQ=IDLE, requests still latch
//   RUN    | stepping through TP1..TP12, waiting for the decision point
//   DECIDE | one cycle after a dispatch edge
module ng_subseq_sched
  import ng_sched_pkg::*;
#(
  parameter int NCNT  = 8,
  parameter int NRUPT = 5
) (
  input logic               CLK1,
  input logic               PURST,
  ng_subseq_sched_if.slave  bus
);

  localparam int CW = $clog2(NCNT);
  localparam int RW = $clog2(NRUPT);

  state_e             state_q, state_d;
  logic [TPG_W-1:0]   tpg_q;
  logic [NCNT-1:0]    cnt_pend_q;
  logic [NRUPT-1:0]   rupt_pend_q;
  logic               iip_q;
  logic               fetch_due_q;
  logic               sni_q;
  logic               inst_q;
  subseq_e            subseq_q;
  logic [CW-1:0]      cnt_addr_q;
  logic [RW-1:0]      rupt_vec_q;

  logic [CW-1:0]      cnt_idx;
  logic               cnt_vld;
  logic [RW-1:0]      rupt_idx;
  logic               rupt_vld;

  logic               decide;
  logic               take_cnt;
  logic               take_rupt;
  logic               take_std;
  logic [NCNT-1:0]    cnt_clr;
  logic [NRUPT-1:0]   rupt_clr;

  ng_prio_enc #(.N(NCNT), .W(CW)) u_cnt_enc (
    .req   (cnt_pend_q),
    .idx   (cnt_idx),
    .valid (cnt_vld)
  );

  ng_prio_enc #(.N(NRUPT), .W(RW)) u_rupt_enc (
    .req   (rupt_pend_q),
    .idx   (rupt_idx),
    .valid (rupt_vld)
  );

  // Only the first cycle at TP12 counts; a held TP12 must not re-dispatch.
  assign decide    = (state_q != STBY) && (bus.TPG == TPG_TP12) && (tpg_q != TPG_TP12);
  assign take_cnt  = decide && cnt_vld;
  assign take_rupt = decide && !cnt_vld && rupt_vld && bus.LAST && !bus.INHINT && !iip_q;
  assign take_std  = decide && !take_cnt && !take_rupt;

  assign cnt_clr  = take_cnt  ? (NCNT'(1)  << cnt_idx)  : '0;
  assign rupt_clr = take_rupt ? (NRUPT'(1) << rupt_idx) : '0;

  always_comb begin
    state_d = state_q;
    if (bus.TPG == TPG_STBY) begin
      state_d = STBY;
    end else if (bus.TPG == TPG_SRLSE || bus.TPG == TPG_WAIT) begin
      state_d = state_q;
    end else begin
      case (state_q)
        STBY:    if (bus.TPG >= TPG_TP1) state_d = RUN;
        RUN:     if (decide) state_d = DECIDE;
        DECIDE:  state_d = decide ? DECIDE : RUN;
        default: state_d = STBY;
      endcase
    end
  end

  always_ff @(posedge CLK1) begin
    if (PURST) begin
      state_q     <= STBY;
      tpg_q       <= TPG_STBY;
      cnt_pend_q  <= '0;
      rupt_pend_q <= '0;
      iip_q       <= 1'b0;
      fetch_due_q <= 1'b1;
      sni_q       <= 1'b0;
      inst_q      <= 1'b0;
      subseq_q    <= SS_IDLE;
      cnt_addr_q  <= '0;
      rupt_vec_q  <= '0;
    end else begin
      state_q     <= state_d;
      tpg_q       <= bus.TPG;
      // A request landing on the dispatch edge re-arms the bit (set wins).
      cnt_pend_q  <= (cnt_pend_q & ~cnt_clr) | bus.CNT_REQ;
      rupt_pend_q <= (rupt_pend_q & ~rupt_clr) | bus.RUPT_REQ;
      inst_q      <= take_std && (bus.LAST || fetch_due_q);

      if (take_cnt) begin
        subseq_q    <= SS_CINC;
        cnt_addr_q  <= cnt_idx;
        sni_q       <= 1'b0;
        fetch_due_q <= fetch_due_q | bus.LAST;
      end else if (take_rupt) begin
        subseq_q    <= SS_RUPT;
        rupt_vec_q  <= rupt_idx;
        sni_q       <= 1'b0;
        fetch_due_q <= fetch_due_q | bus.LAST;
      end else if (take_std) begin
        subseq_q    <= SS_STD;
        sni_q       <= bus.LAST || fetch_due_q;
        fetch_due_q <= 1'b0;
      end else if (state_d == STBY) begin
        subseq_q    <= SS_IDLE;
      end

      if (take_rupt) begin
        iip_q <= 1'b1;
      end else if (bus.RESUME) begin
        iip_q <= 1'b0;
      end
    end
  end

  assign bus.SNI       = sni_q;
  assign bus.INST      = inst_q;
  assign bus.SUBSEQ    = subseq_q;
  assign bus.CNT_ADDR  = cnt_addr_q;
  assign bus.RUPT_VEC  = rupt_vec_q;
  assign bus.CNT_PEND  = cnt_pend_q;
  assign bus.RUPT_PEND = rupt_pend_q;
  assign bus.IIP       = iip_q;

endmodule

// File: tb/tb_ng_subseq_sched.sv
// tb_ng_subseq_sched
//   Bench for ng_subseq_sched: a table of whole-subsequence vectors, a few
//   hand-written multi-cycle sequences, then random traffic compared against
//   an array-based behavioural model.
module tb_ng_subseq_sched;
  import ng_sched_pkg::*;

  localparam int NCNT  = 8;
  localparam int NRUPT = 5;

  logic CLK1 = 1'b0;
  logic PURST;

  ng_subseq_sched_if #(.NCNT(NCNT), .NRUPT(NRUPT)) bus ();

  ng_subseq_sched #(.NCNT(NCNT), .NRUPT(NRUPT)) dut (
    .CLK1  (CLK1),
    .PURST (PURST),
    .bus   (bus)
  );

  always #5 CLK1 = ~CLK1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] subseq, input logic sni,
                         input logic inst, input logic [2:0] addr, input logic [2:0] vec,
                         input logic [7:0] cpend, input logic [4:0] rpend, input logic iip);
    chk({tag, "_subseq"}, bus.SUBSEQ, subseq);
    chk({tag, "_sni"}, bus.SNI, sni);
    chk({tag, "_inst"}, bus.INST, inst);
    chk({tag, "_cnt_addr"}, bus.CNT_ADDR, addr);
    chk({tag, "_rupt_vec"}, bus.RUPT_VEC, vec);
    chk({tag, "_cnt_pend"}, bus.CNT_PEND, cpend);
    chk({tag, "_rupt_pend"}, bus.RUPT_PEND, rpend);
    chk({tag, "_iip"}, bus.IIP, iip);
  endtask

  // One clock: drive inputs, take the edge, leave pulses deasserted after it.
  task automatic step(input logic [3:0] tpg, input logic [7:0] creq = 8'h00,
                      input logic [4:0] rreq = 5'h00, input logic resume = 1'b0,
                      input logic purst = 1'b0);
    bus.TPG      = tpg;
    bus.CNT_REQ  = creq;
    bus.RUPT_REQ = rreq;
    bus.RESUME   = resume;
    PURST        = purst;
    @(posedge CLK1);
    #1;
    bus.CNT_REQ  = '0;
    bus.RUPT_REQ = '0;
    bus.RESUME   = 1'b0;
    PURST        = 1'b0;
  endtask

  task automatic run_to_tp11();
    for (int t = 3; t <= 12; t++) step(4'(t));
  endtask

  typedef struct {
    logic       last;
    logic       inhint;
    logic       resume;
    logic [7:0] creq;
    logic [4:0] rreq;
    logic [1:0] subseq;
    logic       sni;
    logic       inst;
    logic [2:0] addr;
    logic [2:0] vec;
    logic [7:0] cpend;
    logic [4:0] rpend;
    logic       iip;
  } vec_t;

  vec_t tbl[13];

  // ---------------- behavioural reference model ----------------
  bit m_stby;
  int m_prev;
  bit m_cp[NCNT];
  bit m_rp[NRUPT];
  bit m_iip, m_fd, m_sni, m_inst;
  int m_sub, m_addr, m_vec;

  task automatic model_step(input int tpg, input bit last, input bit inh, input bit res,
                            input bit pr, input logic [7:0] creq, input logic [4:0] rreq);
    bit dec, took_rupt;
    int w;
    if (pr) begin
      m_stby = 1; m_prev = 0; m_iip = 0; m_fd = 1; m_sni = 0; m_inst = 0;
      m_sub = 3; m_addr = 0; m_vec = 0;
      foreach (m_cp[i]) m_cp[i] = 0;
      foreach (m_rp[i]) m_rp[i] = 0;
      return;
    end
    dec = !m_stby && tpg == 13 && m_prev != 13;
    took_rupt = 0;
    m_inst = 0;
    if (dec) begin
      w = -1;
      for (int i = NCNT - 1; i >= 0; i--) if (m_cp[i]) w = i;
      if (w >= 0) begin
        m_sub = 1; m_addr = w; m_cp[w] = 0; m_sni = 0;
        if (last) m_fd = 1;
      end else begin
        w = -1;
        for (int i = NRUPT - 1; i >= 0; i--) if (m_rp[i]) w = i;
        if (w >= 0 && last && !inh && !m_iip) begin
          m_sub = 2; m_vec = w; m_rp[w] = 0; m_iip = 1; took_rupt = 1; m_sni = 0; m_fd = 1;
        end else begin
          m_sub = 0; m_sni = last || m_fd; m_inst = m_sni; m_fd = 0;
        end
      end
    end else if (tpg == 0) begin
      m_sub = 3;
    end
    if (res && !took_rupt) m_iip = 0;
    for (int i = 0; i < NCNT; i++) if (creq[i]) m_cp[i] = 1;
    for (int i = 0; i < NRUPT; i++) if (rreq[i]) m_rp[i] = 1;
    if (tpg == 0) m_stby = 1;
    else if (tpg >= 2 && tpg <= 13) m_stby = 0;
    m_prev = tpg;
  endtask

  function automatic logic [7:0] m_cp_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < NCNT; i++) v[i] = m_cp[i];
    return v;
  endfunction

  function automatic logic [4:0] m_rp_vec();
    logic [4:0] v = '0;
    for (int i = 0; i < NRUPT; i++) v[i] = m_rp[i];
    return v;
  endfunction

  initial begin
    int inst_cnt;
    logic [3:0] tg;
    logic [7:0] rc;
    logic [4:0] rr;
    logic rl, rh, rs, rp;

    //            last inh res creq   rreq   subseq   sni inst addr vec cpend  rpend iip
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, SS_STD,  1'b1, 1'b1, 3'd0, 3'd0, 8'h00, 5'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h24, 5'h02, SS_CINC, 1'b0, 1'b0, 3'd2, 3'd0, 8'h20, 5'h02, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, SS_CINC, 1'b0, 1'b0, 3'd5, 3'd0, 8'h00, 5'h02, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, SS_RUPT, 1'b0, 1'b0, 3'd5, 3'd1, 8'h00, 5'h00, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, SS_STD,  1'b1, 1'b1, 3'd5, 3'd1, 8'h00, 5'h00, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 5'h01, SS_STD,  1'b1, 1'b1, 3'd5, 3'd1, 8'h00, 5'h01, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 5'h00, SS_STD,  1'b1, 1'b1, 3'd5, 3'd1, 8'h00, 5'h01, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 5'h00, SS_STD,  1'b1, 1'b1, 3'd5, 3'd1, 8'h00, 5'h01, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, SS_RUPT, 1'b0, 1'b0, 3'd5, 3'd0, 8'h00, 5'h00, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'h00, SS_STD,  1'b1, 1'b1, 3'd5, 3'd0, 8'h00, 5'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'h00, SS_STD,  1'b0, 1'b0, 3'd5, 3'd0, 8'h00, 5'h00, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h80, 5'h00, SS_CINC, 1'b0, 1'b0, 3'd7, 3'd0, 8'h00, 5'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'h00, SS_STD,  1'b1, 1'b1, 3'd7, 3'd0, 8'h00, 5'h00, 1'b0};

    bus.TPG = '0; bus.LAST = 1'b0; bus.CNT_REQ = '0; bus.RUPT_REQ = '0;
    bus.INHINT = 1'b0; bus.RESUME = 1'b0; PURST = 1'b0;

    // Reset with requests present: they must be dropped.
    step(4'd0, 8'hFF, 5'h1F, 1'b0, 1'b1);
    chk_all("reset", SS_IDLE, 0, 0, 0, 0, 8'h00, 5'h00, 0);
    bus.LAST = 1'b1;
    step(4'd0);
    step(4'd1);
    chk("stby_subseq", bus.SUBSEQ, SS_IDLE);

    // Table: one full TP1..TP12 subsequence per row, checked after the TP12
    // edge, then INST must already have dropped on the following edge.
    for (int k = 0; k < 13; k++) begin
      bus.LAST   = tbl[k].last;
      bus.INHINT = tbl[k].inhint;
      step(4'd2, tbl[k].creq, tbl[k].rreq, tbl[k].resume);
      run_to_tp11();
      step(4'd13);
      chk_all($sformatf("row%0d", k), tbl[k].subseq, tbl[k].sni, tbl[k].inst, tbl[k].addr,
              tbl[k].vec, tbl[k].cpend, tbl[k].rpend, tbl[k].iip);
      step(4'd14);
      chk($sformatf("row%0d_inst_drop", k), bus.INST, 1'b0);
      chk($sformatf("row%0d_hold", k), bus.SUBSEQ, tbl[k].subseq);
    end

    // Request on the same edge that dispatches the same counter.
    bus.LAST = 1'b1; bus.INHINT = 1'b0;
    step(4'd2, 8'h08);
    run_to_tp11();
    step(4'd13, 8'h08);
    chk("rearm_subseq", bus.SUBSEQ, SS_CINC);
    chk("rearm_addr", bus.CNT_ADDR, 3'd3);
    chk("rearm_pend", bus.CNT_PEND, 8'h08);
    step(4'd14);
    step(4'd2);
    run_to_tp11();
    step(4'd13);
    chk("rearm2_subseq", bus.SUBSEQ, SS_CINC);
    chk("rearm2_addr", bus.CNT_ADDR, 3'd3);
    chk("rearm2_pend", bus.CNT_PEND, 8'h00);

    // TP12 held four cycles: one decision, one INST pulse; a request that
    // arrives mid-hold stays pending.
    step(4'd14);
    step(4'd2);
    run_to_tp11();
    inst_cnt = 0;
    for (int h = 0; h < 4; h++) begin
      step(4'd13, (h == 1) ? 8'h01 : 8'h00);
      if (bus.INST) inst_cnt++;
    end
    chk("hold13_inst_pulses", inst_cnt, 1);
    chk("hold13_subseq", bus.SUBSEQ, SS_STD);
    chk("hold13_pend", bus.CNT_PEND, 8'h01);
    step(4'd2);
    run_to_tp11();
    step(4'd13);
    chk("hold13_next_subseq", bus.SUBSEQ, SS_CINC);
    chk("hold13_next_addr", bus.CNT_ADDR, 3'd0);

    // Reset in the middle of an interrupt with everything pending.
    step(4'd2, 8'h00, 5'h01);
    run_to_tp11();
    step(4'd13);
    chk("mid_rupt_subseq", bus.SUBSEQ, SS_RUPT);
    chk("mid_rupt_iip", bus.IIP, 1'b1);
    step(4'd2, 8'hFF, 5'h1F);
    for (int t = 3; t <= 6; t++) step(4'(t));
    chk("mid_rupt_cpend", bus.CNT_PEND, 8'hFF);
    chk("mid_rupt_rpend", bus.RUPT_PEND, 5'h1F);
    step(4'd7, 8'hFF, 5'h1F, 1'b0, 1'b1);
    chk_all("purst_mid", SS_IDLE, 0, 0, 0, 0, 8'h00, 5'h00, 0);

    // Random traffic against the model.
    tg = 4'd0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) tg = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 99) < 8) tg = tg;
      else if (tg >= 4'd13) tg = 4'd2;
      else tg = tg + 4'd1;
      rc = 8'($urandom & $urandom & $urandom & $urandom);
      rr = 5'($urandom & $urandom & $urandom & $urandom);
      rl = ($urandom_range(0, 1) == 1);
      rh = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rp = (n == 0) || ($urandom_range(0, 199) == 0);
      bus.TPG = tg; bus.LAST = rl; bus.INHINT = rh; bus.RESUME = rs;
      bus.CNT_REQ = rc; bus.RUPT_REQ = rr; PURST = rp;
      @(posedge CLK1);
      model_step(int'(tg), rl, rh, rs, rp, rc, rr);
      #1;
      chk_all($sformatf("rnd%0d", n), 2'(m_sub), m_sni, m_inst, 3'(m_addr), 3'(m_vec),
              m_cp_vec(), m_rp_vec(), m_iip);
    end
    PURST = 1'b0; bus.CNT_REQ = '0; bus.RUPT_REQ = '0; bus.RESUME = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ng_subseq_sched.md
NG_SUBSEQ_SCHED -- requirements
Module: ng_subseq_sched

Interface
REQ-001 SHALL have params: NCNT 8, number of counter-increment channels; NRUPT 5, number of interrupt channels.
REQ-002 SHALL have ports: CLK1 in 1, sole clock, all state changes on rising edge; PURST in 1, reset, synchronous, active-high.
REQ-003 SHALL have ports: TPG in 4, time pulse count from the time pulse generator; LAST in 1, current instruction ends with this subsequence.
REQ-004 SHALL have ports: CNT_REQ in NCNT, one-cycle increment request pulses; RUPT_REQ in NRUPT, one-cycle interrupt request pulses.
REQ-005 SHALL have ports: INHINT in 1, interrupt inhibit level; RESUME in 1, one-cycle end-of-interrupt pulse.
REQ-006 SHALL have ports: SNI out 1, select-next-instruction level; INST out 1, instruction-increment pulse.
REQ-007 SHALL have ports: SUBSEQ out 2, 0 STD, 1 CINC, 2 RUPT, 3 IDLE; CNT_ADDR out 3, serviced counter; RUPT_VEC out 3, serviced interrupt.
REQ-008 SHALL have ports: CNT_PEND out NCNT and RUPT_PEND out NRUPT, pending bits; IIP out 1, interrupt in progress.

Function
REQ-009 SHALL define a decision point as the first CLK1 cycle with TPG==13 (TP12), detected against a registered copy of TPG; further cycles at 13 are not decision points.
REQ-010 SHALL set CNT_PEND[i] when CNT_REQ[i]=1 and clear it only when channel i is dispatched; set wins if both occur in the same cycle.
REQ-011 SHALL merge a CNT_REQ[i] arriving while CNT_PEND[i]=1 into that bit, with no count kept.
REQ-012 SHALL apply the same set, clear and set-wins rules to RUPT_PEND via RUPT_REQ.
REQ-013 SHALL resolve each decision point with fixed priority: any CNT_PEND first, lowest index wins, giving SUBSEQ=CINC.
REQ-014 SHALL otherwise dispatch RUPT when RUPT_PEND≠0, LAST=1, INHINT=0 and IIP=0, lowest index wins.
REQ-015 SHALL otherwise give SUBSEQ=STD with SNI=LAST.
REQ-016 SHALL register all dispatch outputs at the decision point and hold them until the next decision point.
REQ-017 SHALL on CINC load CNT_ADDR with the winner index and clear that bit on the same edge.
REQ-018 SHALL on RUPT load RUPT_VEC, clear that bit and set IIP.
REQ-019 SHALL clear IIP on RESUME; RESUME in the same cycle as a RUPT dispatch is ignored, dispatch wins.
REQ-020 SHALL hold SNI=0 during CINC and RUPT, so a pending instruction fetch is deferred, not lost; the deferred fetch is STD with SNI=1 at the first decision point where no higher-priority work is taken.
REQ-021 SHALL latch LAST into an internal fetch-due flag at decision points where it is deferred.
REQ-022 SHALL pulse INST high for exactly one cycle after any decision point that asserts SNI.
REQ-023 SHALL use FSM states STBY (TPG 0 or 1, SUBSEQ=IDLE, no dispatch, pending bits still accumulate) -> RUN on TPG 2..13 -> DECIDE, one cycle at the decision point, -> RUN.
REQ-024 SHALL return to STBY from any state when TPG is 0; TPG 14 or 15 holds the current state.
REQ-025 SHALL never dispatch two items at one decision point; every pending bit is eventually serviced if requests stop.

Reset
REQ-026 SHALL on PURST=1 at a CLK1 edge set state STBY, pending bits 0, IIP 0, fetch-due 1, SNI 0, INST 0, SUBSEQ IDLE, CNT_ADDR 0 and RUPT_VEC 0.
REQ-027 SHALL take reset mid-subsequence immediately, discarding all requests.
REQ-028 SHALL ignore requests in the cycle PURST=1.

Structure
REQ-029 SHALL place in shared package ng_sched_pkg: the SUBSEQ encoding, FSM state type, and TPG constants (STBY 0, PWRON 1, TP1 2, TP12 13, SRLSE 14, WAIT 15).
REQ-030 SHALL use one sub-module ng_prio_enc, a parameterised lowest-index-first encoder giving an index and a valid bit, instantiated for counters and for interrupts.

Verification
REQ-031 SHALL cover: reset, then TPG stepped 0,1,2..13 with LAST=1 and no requests -> SUBSEQ=STD, SNI=1 and a single INST pulse after the TP12 edge.
REQ-032 SHALL cover: CNT_REQ=0x24 and RUPT_REQ[1] before TP12 -> CINC with CNT_ADDR=2, then CINC with 5, then RUPT with VEC=1 and IIP=1 on three successive TP12s.
REQ-033 SHALL cover: INHINT=1 with RUPT_PEND=0x01 over three subsequences -> no RUPT; INHINT drops -> RUPT at next TP12 with LAST=1.
REQ-034 SHALL cover: CNT_REQ[3] pulsed in the same cycle CNT_PEND[3] is dispatched -> CNT_PEND[3] stays 1 and is serviced at the next TP12.
REQ-035 SHALL cover: TPG held at 13 for 4 cycles -> exactly one decision and one INST pulse.
REQ-036 SHALL cover: PURST mid-RUPT with IIP=1 and pending 0xFF -> all cleared next cycle and SUBSEQ=IDLE.
